game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Top-level game sequencer for the asteroid VGA game; instantiated in top_vga beside vga_timing, ship, score.
//  Runs ATTRACT/PLAY/RESPAWN/OVER state machine, owns score and lives, generates per-frame move strobe,
//  wave reset and free-running RNG counter. Ship/asteroid/bullet blocks consume its outputs; score block displays score.
// PARAMETERS
//  LIVES_INIT      3    lives loaded at game start (1..3)
//  RESPAWN_FRAMES  120  frames spent in RESPAWN after a hit (1..255)
//  OVER_FRAMES     180  frames spent in OVER before returning to ATTRACT (1..255)
//  SCORE_W         8    score width; score saturates at 2**SCORE_W-1
//  EXTRA_LIFE_PTS  50   score interval for bonus life (used only with GAME_EXTRA_LIFE_EN)
// PORTS
//  clk          in   1        100 MHz board clock
//  rst          in   1        synchronous, active-high reset
//  pixpulse     in   1        1-of-4 clk enable (25 MHz pixel rate)
//  vblank       in   1        from vga_timing
//  start        in   1        shoot button, level; start on rising edge
//  ship_hit     in   1        ship collided this pixel (level, sampled on pixpulse)
//  kill_cnt     in   3        asteroids destroyed, valid 1 pixpulse cycle (0..7)
//  all_broken   in   1        no asteroids left on screen
//  game_state   out  2        0 ATTRACT,1 PLAY,2 RESPAWN,3 OVER
//  move         out  1        1-clk frame strobe to movers
//  ship_en      out  1        ship drawn/collidable (PLAY only)
//  wave_reset   out  1        1-clk pulse: respawn asteroid field
//  score        out  SCORE_W  current score
//  lives        out  2        remaining lives
//  timer_rng    out  8        free-running frame counter for pseudo-random use
// BEHAVIOUR
//  - All state changes only on clk edges where pixpulse=1; all outputs registered.
//  - Reset (incl. mid-game): state ATTRACT, score 0, lives 0, move/wave_reset/ship_en 0, timer_rng 0, frame cnt 0.
//  - Frame tick: vblank registered (vblank_d1) on pixpulse; tick = pixpulse & vblank & ~vblank_d1.
//  - move = tick in PLAY or RESPAWN (asteroids keep moving); 0 in ATTRACT/OVER. Asserted exactly one clk.
//  - timer_rng += 1 (mod 256) every tick, all states. start edge = start & ~start_d1 on pixpulse.
//  - ATTRACT: start edge -> PLAY; score<=0, lives<=LIVES_INIT, wave_reset pulse same clk.
//  - PLAY: score += kill_cnt, saturating at max. ship_hit -> RESPAWN, lives-=1, frame cnt<=0;
//    if lives was 1 -> OVER instead (lives 0). kill_cnt and ship_hit same cycle: score credited, then hit.
//    all_broken at tick -> wave_reset pulse on that clk, stay PLAY.
//  - RESPAWN: ship_hit ignored; kills still scored; count ticks; at RESPAWN_FRAMES -> PLAY.
//  - OVER: inputs ignored, score held; count ticks; at OVER_FRAMES -> ATTRACT (score/lives held for display).
//  - start held through a transition does not re-trigger (edge only). ship_en = (state==PLAY).
// CONFIGURATION
//  GAME_EXTRA_LIFE_EN defined: each time score crosses a multiple of EXTRA_LIFE_PTS, lives += 1,
//    saturating at 3; crossing detected on the pre/post-add values, at most one bonus per cycle.
//  Undefined: lives only decrement; EXTRA_LIFE_PTS unused; no bonus logic synthesised.
// STRUCTURE
//  game_pkg: state encodings (ST_ATTRACT..ST_OVER), colour constants, LIVES_W=2.
//  Sub-module frame_timer: tick generator + 8-bit frame counter with clear/terminal-count compare;
//    used for RESPAWN/OVER timing; timer_rng held in parent.
// TESTING
//  1 rst, 2 frames, start pulse -> game_state=1, lives=3, score=0, wave_reset one clk, move one clk per frame.
//  2 PLAY, kill_cnt=3 x 90 events -> score saturates at 255, never wraps.
//  3 ship_hit with lives=3 -> state 2, lives=2; ship_hit during RESPAWN ignored; after 120 ticks -> state 1.
//  4 third hit -> state 3, lives=0; 180 ticks -> state 0; score held; start held high does not restart.
//  5 kill_cnt=2 and ship_hit same cycle at score 10 -> score 12, lives decremented; rst mid-RESPAWN -> all reset values.
//  6 GAME_EXTRA_LIFE_EN, score 48 + kill_cnt 3 -> score 51, lives+1 (cap 3); same stimulus w/o macro -> lives unchanged.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg
//   Shared encodings for the asteroid game sequencer and its neighbours:
//   game state encodings, lives width, RNG width and display colours.
//   Imported by game_ctrl_if and game_ctrl.
package game_pkg;

  localparam int LIVES_W = 2;
  localparam int RNG_W   = 8;

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RESPAWN = 2'd2,
    ST_OVER    = 2'd3
  } game_state_e;

  // 12-bit RGB colours shared by the drawing blocks
  localparam logic [11:0] COL_SHIP     = 12'hFFF;
  localparam logic [11:0] COL_ASTEROID = 12'h888;
  localparam logic [11:0] COL_BULLET   = 12'hFF0;
  localparam logic [11:0] COL_TEXT     = 12'h0F0;

  // Lives increment that sticks at the largest representable count
  function automatic logic [LIVES_W-1:0] lives_inc_sat(input logic [LIVES_W-1:0] l);
    return (l == '1) ? l : l + 1'b1;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if
//   Bundles the game sequencer's inputs (from vga_timing, collision logic,
//   buttons) and outputs (to ship/asteroid/bullet/score blocks).
//   master : game_ctrl side (consumes inputs, drives outputs)
//   slave  : surrounding game logic side
//   Parameter SCORE_W sets the score width.
interface game_ctrl_if
  import game_pkg::*;
#(
  parameter int SCORE_W = 8
);
  logic                pixpulse;
  logic                vblank;
  logic                start;
  logic                ship_hit;
  logic [2:0]          kill_cnt;
  logic                all_broken;
  logic [1:0]          game_state;
  logic                move;
  logic                ship_en;
  logic                wave_reset;
  logic [SCORE_W-1:0]  score;
  logic [LIVES_W-1:0]  lives;
  logic [RNG_W-1:0]    timer_rng;

  modport master (
    input  pixpulse, vblank, start, ship_hit, kill_cnt, all_broken,
    output game_state, move, ship_en, wave_reset, score, lives, timer_rng
  );

  modport slave (
    output pixpulse, vblank, start, ship_hit, kill_cnt, all_broken,
    input  game_state, move, ship_en, wave_reset, score, lives, timer_rng
  );
endinterface

// File: rtl/frame_timer.sv
// frame_timer
//   Frame tick generator (rising edge of vblank, sampled at pixel rate) and
//   an 8-bit frame counter with synchronous clear and terminal-count compare.
// Ports
//   clk, rst  : clock, synchronous active-high reset
//   pixpulse  : pixel-rate clock enable
//   vblank    : vertical blank from vga_timing
//   clr       : restart the count at zero
//   limit     : number of ticks to count (1..255)
//   tick      : one-clk frame tick (combinational)
//   done      : high on the tick that completes 'limit' counted ticks
module frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixpulse,
  input  logic       vblank,
  input  logic       clr,
  input  logic [7:0] limit,
  output logic       tick,
  output logic       done
);
  logic       vblank_d1_q, vblank_d1_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    tick        = pixpulse & vblank & ~vblank_d1_q;
    vblank_d1_d = pixpulse ? vblank : vblank_d1_q;
    // cnt_q holds ticks already counted, so this tick is number limit
    done        = tick & (cnt_q == limit - 8'd1);
    cnt_d       = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblank_d1_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      vblank_d1_q <= vblank_d1_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl
//   Top-level sequencer for the asteroid VGA game. Runs the
//   ATTRACT/PLAY/RESPAWN/OVER state machine, owns score and lives, and
//   generates the per-frame move strobe, wave reset and RNG frame counter.
//   All state advances only on clk edges with pixpulse=1; outputs registered.
// Ports
//   clk  : 100 MHz board clock
//   rst  : synchronous active-high reset
//   bus  : game_ctrl_if.master (pixpulse, vblank, start, ship_hit, kill_cnt,
//          all_broken in; game_state, move, ship_en, wave_reset, score,
//          lives, timer_rng out)
// Build option
//   GAME_EXTRA_LIFE_EN : award one life (max 3) each time the score crosses
//                        a multiple of EXTRA_LIFE_PTS.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_ATTRACT | idle/title, waits for start edge
// ST_PLAY    | ship live, kills scored, hits cost a life
// ST_RESPAWN | ship hidden for RESPAWN_FRAMES, kills still scored
// ST_OVER    | final score shown for OVER_FRAMES, inputs ignored
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int RESPAWN_FRAMES = 120,
  parameter int OVER_FRAMES    = 180,
`ifdef GAME_EXTRA_LIFE_EN
  parameter int unsigned EXTRA_LIFE_PTS = 50,
`endif
  parameter int SCORE_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  game_ctrl_if.master bus
);
  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d, score_sat;
  logic [SCORE_W:0]   score_sum;
  logic [LIVES_W-1:0] lives_q, lives_d, lives_adj;
  logic [RNG_W-1:0]   timer_rng_q, timer_rng_d;
  logic               start_d1_q, start_d1_d;
  logic               move_q, move_d;
  logic               ship_en_q, ship_en_d;
  logic               wave_reset_q, wave_reset_d;
  logic               tick, timer_done, timer_clr;
  logic [7:0]         timer_limit;
`ifdef GAME_EXTRA_LIFE_EN
  logic               bonus;
`endif

  assign timer_limit = (state_q == ST_OVER) ? 8'(OVER_FRAMES) : 8'(RESPAWN_FRAMES);

  frame_timer u_frame_timer (
    .clk      (clk),
    .rst      (rst),
    .pixpulse (bus.pixpulse),
    .vblank   (bus.vblank),
    .clr      (timer_clr),
    .limit    (timer_limit),
    .tick     (tick),
    .done     (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    lives_d      = lives_q;
    wave_reset_d = 1'b0;
    timer_clr    = 1'b0;
    start_d1_d   = bus.pixpulse ? bus.start : start_d1_q;
    move_d       = tick & ((state_q == ST_PLAY) | (state_q == ST_RESPAWN));
    timer_rng_d  = tick ? timer_rng_q + 1'b1 : timer_rng_q;

    // Saturating score add; the carry bit flags overflow
    score_sum = {1'b0, score_q} + {{(SCORE_W-2){1'b0}}, bus.kill_cnt};
    score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

`ifdef GAME_EXTRA_LIFE_EN
    bonus     = (32'(score_q) / EXTRA_LIFE_PTS) != (32'(score_sat) / EXTRA_LIFE_PTS);
    lives_adj = bonus ? lives_inc_sat(lives_q) : lives_q;
`else
    lives_adj = lives_q;
`endif

    if (bus.pixpulse) begin
      unique case (state_q)
        ST_ATTRACT: begin
          if (bus.start & ~start_d1_q) begin
            state_d      = ST_PLAY;
            score_d      = '0;
            lives_d      = LIVES_W'(LIVES_INIT);
            wave_reset_d = 1'b1;
          end
        end
        ST_PLAY: begin
          // Kills in the hit cycle are credited before the hit is applied
          score_d = score_sat;
          lives_d = lives_adj;
          if (bus.ship_hit) begin
            timer_clr = 1'b1;
            if (lives_adj == LIVES_W'(1)) begin
              state_d = ST_OVER;
              lives_d = '0;
            end else begin
              state_d = ST_RESPAWN;
              lives_d = lives_adj - 1'b1;
            end
          end else if (tick & bus.all_broken) begin
            wave_reset_d = 1'b1;
          end
        end
        ST_RESPAWN: begin
          score_d = score_sat;
          lives_d = lives_adj;
          if (timer_done) state_d = ST_PLAY;
        end
        ST_OVER: begin
          if (timer_done) state_d = ST_ATTRACT;
        end
      endcase
    end

    ship_en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ATTRACT;
      score_q      <= '0;
      lives_q      <= '0;
      timer_rng_q  <= '0;
      start_d1_q   <= 1'b0;
      move_q       <= 1'b0;
      ship_en_q    <= 1'b0;
      wave_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      timer_rng_q  <= timer_rng_d;
      start_d1_q   <= start_d1_d;
      move_q       <= move_d;
      ship_en_q    <= ship_en_d;
      wave_reset_q <= wave_reset_d;
    end
  end

  assign bus.game_state = state_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.timer_rng  = timer_rng_q;
  assign bus.move       = move_q;
  assign bus.ship_en    = ship_en_q;
  assign bus.wave_reset = wave_reset_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl
//   Directed bench for game_ctrl: start sequence, score saturation, respawn
//   and game-over timing, simultaneous kill+hit, mid-game reset, extra life.
module tb_game_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  game_ctrl_if #(.SCORE_W(8)) bus ();

  game_ctrl #(
    .LIVES_INIT     (3),
    .RESPAWN_FRAMES (120),
    .OVER_FRAMES    (180),
    .SCORE_W        (8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // pixpulse high around every fourth rising edge, changing only on falling edges
  initial begin
    bus.pixpulse = 1'b0;
    #10;
    forever begin
      bus.pixpulse = 1'b1;
      #10 bus.pixpulse = 1'b0;
      #30;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // advance to just after the next enabled clock edge
  task automatic pclk();
    do @(posedge clk); while (!bus.pixpulse);
    #2;
  endtask

  task automatic next_clk();
    @(posedge clk);
    #2;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.vblank = 1'b1; pclk();
      bus.vblank = 1'b0; pclk();
    end
  endtask

  task automatic kills(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      bus.kill_cnt = 3'(k); pclk();
    end
    bus.kill_cnt = 3'd0;
  endtask

  task automatic start_game();
    bus.start = 1'b0; pclk();
    bus.start = 1'b1; pclk();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) next_clk();
    rst = 1'b0;
    next_clk();
    checks++; if (bus.game_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.game_state); end
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", bus.score); end
    checks++; if (bus.lives !== 2'd0) begin failures++; $display("FAIL reset_lives got=%0d exp=0", bus.lives); end
    checks++; if ({bus.move, bus.wave_reset, bus.ship_en} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {bus.move, bus.wave_reset, bus.ship_en}); end
    checks++; if (bus.timer_rng !== 8'd0) begin failures++; $display("FAIL reset_rng got=%0d exp=0", bus.timer_rng); end
  endtask

  task automatic test_start();
    for (int f = 0; f < 2; f++) begin
      bus.vblank = 1'b1; pclk();
      checks++; if (bus.move !== 1'b0) begin failures++; $display("FAIL attract_move got=%0b exp=0", bus.move); end
      bus.vblank = 1'b0; pclk();
    end
    checks++; if (bus.timer_rng !== 8'd2) begin failures++; $display("FAIL attract_rng got=%0d exp=2", bus.timer_rng); end
    checks++; if (bus.game_state !== 2'd0) begin failures++; $display("FAIL attract_hold got=%0d exp=0", bus.game_state); end
    bus.start = 1'b1; pclk();
    checks++; if (bus.game_state !== 2'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", bus.game_state); end
    checks++; if (bus.lives !== 2'd3) begin failures++; $display("FAIL start_lives got=%0d exp=3", bus.lives); end
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL start_score got=%0d exp=0", bus.score); end
    checks++; if (bus.wave_reset !== 1'b1) begin failures++; $display("FAIL start_wave got=%0b exp=1", bus.wave_reset); end
    checks++; if (bus.ship_en !== 1'b1) begin failures++; $display("FAIL start_ship_en got=%0b exp=1", bus.ship_en); end
    next_clk();
    checks++; if (bus.wave_reset !== 1'b0) begin failures++; $display("FAIL start_wave_width got=%0b exp=0", bus.wave_reset); end
    bus.start = 1'b0;
    bus.vblank = 1'b1; pclk();
    checks++; if (bus.move !== 1'b1) begin failures++; $display("FAIL play_move got=%0b exp=1", bus.move); end
    checks++; if (bus.wave_reset !== 1'b0) begin failures++; $display("FAIL play_no_wave got=%0b exp=0", bus.wave_reset); end
    next_clk();
    checks++; if (bus.move !== 1'b0) begin failures++; $display("FAIL play_move_width got=%0b exp=0", bus.move); end
    bus.vblank = 1'b0; pclk();
    bus.all_broken = 1'b1; pclk();
    checks++; if (bus.wave_reset !== 1'b0) begin failures++; $display("FAIL broken_no_tick got=%0b exp=0", bus.wave_reset); end
    bus.vblank = 1'b1; pclk();
    checks++; if ({bus.wave_reset, bus.move} !== 2'b11) begin failures++; $display("FAIL broken_tick got=%b exp=11", {bus.wave_reset, bus.move}); end
    bus.all_broken = 1'b0;
    bus.vblank = 1'b0; pclk();
    checks++; if (bus.timer_rng !== 8'd4) begin failures++; $display("FAIL play_rng got=%0d exp=4", bus.timer_rng); end
  endtask

  task automatic test_score_saturate();
    logic [7:0] prev;
    bit wrapped;
    wrapped = 1'b0;
    prev = bus.score;
    for (int i = 1; i <= 90; i++) begin
      bus.kill_cnt = 3'd3; pclk();
      bus.kill_cnt = 3'd0;
      if (bus.score < prev) wrapped = 1'b1;
      prev = bus.score;
      if (i == 84) begin
        checks++; if (bus.score !== 8'd252) begin failures++; $display("FAIL score_84 got=%0d exp=252", bus.score); end
      end
    end
    checks++; if (bus.score !== 8'd255) begin failures++; $display("FAIL score_sat got=%0d exp=255", bus.score); end
    checks++; if (wrapped !== 1'b0) begin failures++; $display("FAIL score_wrap got=%0b exp=0", wrapped); end
  endtask

  task automatic test_respawn();
    bus.ship_hit = 1'b1; pclk();
    bus.ship_hit = 1'b0;
    checks++; if (bus.game_state !== 2'd2) begin failures++; $display("FAIL hit1_state got=%0d exp=2", bus.game_state); end
    checks++; if (bus.lives !== 2'd2) begin failures++; $display("FAIL hit1_lives got=%0d exp=2", bus.lives); end
    checks++; if (bus.ship_en !== 1'b0) begin failures++; $display("FAIL hit1_ship_en got=%0b exp=0", bus.ship_en); end
    bus.ship_hit = 1'b1; pclk();
    bus.ship_hit = 1'b0;
    checks++; if ({bus.game_state, bus.lives} !== {2'd2, 2'd2}) begin failures++; $display("FAIL respawn_hit_ignored got=%0d/%0d exp=2/2", bus.game_state, bus.lives); end
    bus.vblank = 1'b1; pclk();
    checks++; if (bus.move !== 1'b1) begin failures++; $display("FAIL respawn_move got=%0b exp=1", bus.move); end
    bus.vblank = 1'b0; pclk();
    frames(118);
    checks++; if (bus.game_state !== 2'd2) begin failures++; $display("FAIL respawn_119 got=%0d exp=2", bus.game_state); end
    bus.vblank = 1'b1; pclk();
    checks++; if (bus.game_state !== 2'd1) begin failures++; $display("FAIL respawn_120 got=%0d exp=1", bus.game_state); end
    checks++; if (bus.ship_en !== 1'b1) begin failures++; $display("FAIL respawn_ship_en got=%0b exp=1", bus.ship_en); end
    bus.vblank = 1'b0; pclk();
  endtask

  task automatic test_game_over();
    bus.ship_hit = 1'b1; pclk();
    bus.ship_hit = 1'b0;
    checks++; if (bus.lives !== 2'd1) begin failures++; $display("FAIL hit2_lives got=%0d exp=1", bus.lives); end
    frames(120);
    checks++; if (bus.game_state !== 2'd1) begin failures++; $display("FAIL hit2_back got=%0d exp=1", bus.game_state); end
    bus.ship_hit = 1'b1; pclk();
    bus.ship_hit = 1'b0;
    checks++; if (bus.game_state !== 2'd3) begin failures++; $display("FAIL hit3_state got=%0d exp=3", bus.game_state); end
    checks++; if (bus.lives !== 2'd0) begin failures++; $display("FAIL hit3_lives got=%0d exp=0", bus.lives); end
    bus.start = 1'b1;
    bus.kill_cnt = 3'd1;
    frames(179);
    bus.kill_cnt = 3'd0;
    checks++; if (bus.game_state !== 2'd3) begin failures++; $display("FAIL over_179 got=%0d exp=3", bus.game_state); end
    bus.vblank = 1'b1; pclk();
    checks++; if (bus.game_state !== 2'd0) begin failures++; $display("FAIL over_180 got=%0d exp=0", bus.game_state); end
    checks++; if (bus.score !== 8'd255) begin failures++; $display("FAIL over_score got=%0d exp=255", bus.score); end
    bus.vblank = 1'b0;
    repeat (4) pclk();
    checks++; if (bus.game_state !== 2'd0) begin failures++; $display("FAIL held_start got=%0d exp=0", bus.game_state); end
    bus.start = 1'b0; pclk();
  endtask

  task automatic test_hit_and_kill();
    start_game();
    checks++; if ({bus.game_state, bus.score} !== {2'd1, 8'd0}) begin failures++; $display("FAIL restart got=%0d/%0d exp=1/0", bus.game_state, bus.score); end
    kills(5, 2);
    bus.kill_cnt = 3'd2; bus.ship_hit = 1'b1; pclk();
    bus.kill_cnt = 3'd0; bus.ship_hit = 1'b0;
    checks++; if (bus.score !== 8'd12) begin failures++; $display("FAIL kill_hit_score got=%0d exp=12", bus.score); end
    checks++; if ({bus.game_state, bus.lives} !== {2'd2, 2'd2}) begin failures++; $display("FAIL kill_hit_state got=%0d/%0d exp=2/2", bus.game_state, bus.lives); end
    frames(10);
    rst = 1'b1; next_clk();
    rst = 1'b0;
    checks++; if ({bus.game_state, bus.score, bus.lives} !== {2'd0, 8'd0, 2'd0}) begin failures++; $display("FAIL midreset got=%0d/%0d/%0d exp=0/0/0", bus.game_state, bus.score, bus.lives); end
    checks++; if ({bus.move, bus.wave_reset, bus.ship_en, bus.timer_rng} !== 11'd0) begin failures++; $display("FAIL midreset_out got=%b exp=0", {bus.move, bus.wave_reset, bus.ship_en, bus.timer_rng}); end
  endtask

  task automatic test_extra_life();
    logic [1:0] exp_l;
`ifdef GAME_EXTRA_LIFE_EN
    exp_l = 2'd3;
`else
    exp_l = 2'd2;
`endif
    start_game();
    kills(6, 8);
    checks++; if (bus.score !== 8'd48) begin failures++; $display("FAIL xl_score48 got=%0d exp=48", bus.score); end
    bus.ship_hit = 1'b1; pclk();
    bus.ship_hit = 1'b0;
    checks++; if (bus.lives !== 2'd2) begin failures++; $display("FAIL xl_hit got=%0d exp=2", bus.lives); end
    kills(3, 1);
    checks++; if (bus.score !== 8'd51) begin failures++; $display("FAIL xl_score51 got=%0d exp=51", bus.score); end
    checks++; if (bus.lives !== exp_l) begin failures++; $display("FAIL xl_bonus got=%0d exp=%0d", bus.lives, exp_l); end
    kills(7, 7);
    checks++; if (bus.score !== 8'd100) begin failures++; $display("FAIL xl_score100 got=%0d exp=100", bus.score); end
    checks++; if (bus.lives !== exp_l) begin failures++; $display("FAIL xl_cap got=%0d exp=%0d", bus.lives, exp_l); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.vblank = 1'b0;
    bus.start = 1'b0;
    bus.ship_hit = 1'b0;
    bus.kill_cnt = 3'd0;
    bus.all_broken = 1'b0;
    test_reset();
    test_start();
    test_score_saturate();
    test_respawn();
    test_game_over();
    test_hit_and_kill();
    test_extra_life();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
